cfu_cmd_issuer: RTL

Initiator side of the CPU↔CFU cmd/rsp handshake. It buffers host commands (function_id, inputs_0, inputs_1) in a command FIFO and issues them one at a time on the CFU cmd_* channel. It collects each rsp_payload_outputs_0 into a response FIFO for the host. It sits between a test/host sequencer and the Cfu block, and drives that block from on-chip logic.

---
 rtl/cfu_cmd_issuer_pkg.sv | 22 ++
 rtl/cfu_cmd_issuer_if.sv | 28 ++
 rtl/cfu_sync_fifo.sv | 60 ++++++
 rtl/cfu_cmd_issuer.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/cfu_cmd_issuer_pkg.sv
// Shared types and constants for the CFU command issuer.
// Optional response watchdog is enabled by defining CFU_ISSUER_TIMEOUT_EN.
package cfu_issuer_pkg;

    localparam int FUNC_ID_W = 10;
    localparam int DATA_W    = 32;

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef struct packed {
        logic [FUNC_ID_W-1:0] function_id;
        logic [DATA_W-1:0]    inputs_0;
        logic [DATA_W-1:0]    inputs_1;
    } cmd_entry_t;

endpackage

// File: rtl/cfu_cmd_issuer_if.sv
// CPU<->CFU cmd/rsp channel; master is the issuer, slave is the CFU.
interface cfu_cmd_issuer_if;
    import cfu_issuer_pkg::*;

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [FUNC_ID_W-1:0] cmd_payload_function_id;
    logic [DATA_W-1:0]    cmd_payload_inputs_0;
    logic [DATA_W-1:0]    cmd_payload_inputs_1;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [DATA_W-1:0]    rsp_payload_outputs_0;

    modport master (
        output cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1,
        input  cmd_ready,
        input  rsp_valid, rsp_payload_outputs_0,
        output rsp_ready
    );

    modport slave (
        input  cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1,
        output cmd_ready,
        output rsp_valid, rsp_payload_outputs_0,
        input  rsp_ready
    );

endinterface

// File: rtl/cfu_sync_fifo.sv
// Show-ahead synchronous FIFO with count-based full/empty flags.
module cfu_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("cfu_sync_fifo: DEPTH must be a power of two >= 2");
    end

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == {CW{1'b0}});
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign dout      = mem_r[rd_ptr_r];

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/cfu_cmd_issuer.sv
// Buffers host commands, issues them one at a time to a CFU and queues results.
// Define CFU_ISSUER_TIMEOUT_EN to add a response watchdog and an error flag per result.
module cfu_cmd_issuer
    import cfu_issuer_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [FUNC_ID_W-1:0] req_function_id,
    input  logic [DATA_W-1:0]    req_inputs_0,
    input  logic [DATA_W-1:0]    req_inputs_1,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [DATA_W-1:0]    res_data,
    output logic                 res_error,
    cfu_cmd_issuer_if.master     cfu,
    output logic                 busy,
    output logic [15:0]          issued_count
);
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("cfu_cmd_issuer: TIMEOUT must be >= 1");
    end

`ifdef CFU_ISSUER_TIMEOUT_EN
    localparam int RSP_W = DATA_W + 1;
    localparam int TO_W  = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [TO_W-1:0] to_cnt_r;
`else
    localparam int RSP_W = DATA_W;
`endif

    state_t           state_r;
    state_t           state_nxt_s;
    cmd_entry_t       cmd_head_s;
    logic             cmd_full_s;
    logic             cmd_empty_s;
    logic             cmd_pop_s;
    logic             rsp_full_s;
    logic             rsp_empty_s;
    logic             rsp_push_s;
    logic [RSP_W-1:0] rsp_din_s;
    logic [RSP_W-1:0] rsp_dout_s;

    cfu_sync_fifo #(.WIDTH($bits(cmd_entry_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (req_valid),
        .din     ({req_function_id, req_inputs_0, req_inputs_1}),
        .pop     (cmd_pop_s),
        .dout    (cmd_head_s),
        .full    (cmd_full_s),
        .empty   (cmd_empty_s)
    );

    cfu_sync_fifo #(.WIDTH(RSP_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (rsp_push_s),
        .din     (rsp_din_s),
        .pop     (res_ready),
        .dout    (rsp_dout_s),
        .full    (rsp_full_s),
        .empty   (rsp_empty_s)
    );

    assign req_ready = !cmd_full_s;
    assign res_valid = !rsp_empty_s;
    assign res_data  = rsp_dout_s[DATA_W-1:0];
`ifdef CFU_ISSUER_TIMEOUT_EN
    assign res_error = rsp_dout_s[DATA_W];
`else
    assign res_error = 1'b0;
`endif

    assign cfu.cmd_payload_function_id = cmd_head_s.function_id;
    assign cfu.cmd_payload_inputs_0    = cmd_head_s.inputs_0;
    assign cfu.cmd_payload_inputs_1    = cmd_head_s.inputs_1;
    // The CFU loops cmd_valid/rsp_ready back combinationally, so both decode from state only.
    assign cfu.cmd_valid = (state_r == ISSUE);
    assign cfu.rsp_ready = (state_r == ISSUE) || (state_r == WAIT);
    assign busy          = (state_r != IDLE);

    // Next-state decode, cmd pop and rsp push.
    always_comb begin
        state_nxt_s = state_r;
        cmd_pop_s   = 1'b0;
        rsp_push_s  = 1'b0;
        rsp_din_s   = RSP_W'(cfu.rsp_payload_outputs_0);
        case (state_r)
            IDLE: begin
                // Entering ISSUE only with a free rsp slot reserves it for this command.
                if (!cmd_empty_s && !rsp_full_s) begin
                    state_nxt_s = ISSUE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                if (cfu.cmd_ready) begin
                    cmd_pop_s = 1'b1;
                    if (cfu.rsp_valid) begin
                        rsp_push_s  = 1'b1;
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = WAIT;
                    end
                end else begin
                    state_nxt_s = ISSUE;
                end
            end
            WAIT: begin
                if (cfu.rsp_valid) begin
                    rsp_push_s  = 1'b1;
                    state_nxt_s = IDLE;
`ifdef CFU_ISSUER_TIMEOUT_EN
                end else if (to_cnt_r == TO_W'(TIMEOUT - 1)) begin
                    rsp_push_s  = 1'b1;
                    rsp_din_s   = {1'b1, TIMEOUT_DATA};
                    state_nxt_s = IDLE;
`endif
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register and completed-handshake counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            issued_count <= 16'd0;
        end else begin
            state_r <= state_nxt_s;
            if (cmd_pop_s) begin
                issued_count <= issued_count + 16'd1;
            end
        end
    end

`ifdef CFU_ISSUER_TIMEOUT_EN
    // Watchdog: zero outside WAIT, counts WAIT cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt_r <= {TO_W{1'b0}};
        end else if (state_r != WAIT) begin
            to_cnt_r <= {TO_W{1'b0}};
        end else begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
        end
    end
`endif

endmodule
